multu_hilo: RTL and testbench
=============================

// Module: multu_hilo
// PURPOSE
//   Unsigned 32x32 sequential shift-add multiplier with the HI/LO result registers.
//   Sits directly downstream of the ALU control stage and is driven by its 6-bit SignaltoMULTU output.
//   Runs 32 iterations while the opcode is MULTU.
//   Commits the 64-bit product to HI/LO only when control issues the OPEN_HILO code (6'b111111).
//   HiOut/LoOut feed the result mux used by MFHI/MFLO.
// PARAMETERS
//   WIDTH      32         operand width; product is 2*WIDTH, iteration count = WIDTH
//   MULTU      6'b011001  opcode that starts/continues a multiply
//   OPEN_HILO  6'b111111  opcode that commits product into HI/LO
// PORTS
//   clk      in   1        rising-edge clock
//   rst      in   1        synchronous, active-high reset
//   Signal   in   6        opcode from ALU control (SignaltoMULTU)
//   dataA    in   WIDTH    multiplicand (unsigned)
//   dataB    in   WIDTH    multiplier (unsigned)
//   HiOut    out  WIDTH    HI register (product[2W-1:W])
//   LoOut    out  WIDTH    LO register (product[W-1:0])
//   busy     out  1        1 while state==RUN
//   done     out  1        1 while state==DONE (product valid, awaiting commit)
// BEHAVIOUR
//   Reset: one clk edge with rst=1 gives state=IDLE, HiOut=LoOut=0, busy=done=0; internal regs cleared.
//     rst has priority over every other event, including mid-RUN and in DONE.
//   State machine: IDLE -> RUN -> DONE -> IDLE. All updates occur on posedge clk.
//   IDLE:
//     - If Signal==MULTU: mcand(2W)<={0,dataA}, mplier<=dataB, prod<=0, cnt<=0, state<=RUN.
//     - Otherwise hold. OPEN_HILO in IDLE is ignored; HI/LO unchanged.
//   RUN, per edge with Signal==MULTU:
//     - If mplier[0]: prod<=prod+mcand (2W-bit add, no overflow possible).
//     - Then mcand<<=1, mplier>>=1, cnt<=cnt+1.
//     - On the edge where cnt==W-1: state<=DONE.
//     - Exactly W RUN edges; operands are sampled only at the IDLE->RUN edge.
//   RUN, Signal!=MULTU (abort): state<=IDLE; prod discarded; HI/LO unchanged; no commit.
//   DONE, Signal==OPEN_HILO: HiOut<=prod[2W-1:W], LoOut<=prod[W-1:0], state<=IDLE.
//   DONE, Signal==MULTU: hold (waiting for commit).
//   DONE, any other opcode: state<=IDLE without commit.
//   Timing vs control (MULTU held):
//     - Edge 1 loads; edges 2..33 iterate; DONE after edge 33.
//     - Control presents OPEN_HILO after its 33rd edge, so commit happens on edge 34.
//     - HiOut/LoOut are valid after edge 34.
//     - If MULTU is still held, edge 35 starts a new multiply from IDLE.
//   HiOut/LoOut change only on commit or reset.
//   busy and done are registered state decodes and are never both 1.
//   cnt width is clog2(WIDTH); no wrap beyond W-1 is used.
// TESTING
//   1. rst=1 one edge, then rst=0, Signal=0 -> HiOut=LoOut=0, busy=0, done=0.
//   2. A=7, B=9, MULTU held 33 edges, then OPEN_HILO 1 edge -> busy 32 cycles, done=1 after edge 33, HI=0, LO=63 after edge 34.
//   3. A=B=32'hFFFFFFFF, full sequence -> HI=32'hFFFFFFFE, LO=32'h00000001.
//   4. A=32'h80000000, B=2, full sequence -> HI=1, LO=0. Then drive Signal=6'b100000 (ADD) at edge 10 of a second multiply -> state=IDLE, HI=1/LO=0 retained.
//   5. Reset mid-RUN at iteration 16 -> all outputs 0, IDLE. Then A=3, B=5 full sequence -> LO=15.
//   6. OPEN_HILO in IDLE with prior HI/LO=0/63 -> unchanged. Changing dataA/dataB mid-RUN -> product still from operands sampled at load.

Source files
------------

// File: rtl/multu_hilo.sv
// Unsigned WIDTH x WIDTH shift-add multiplier that holds its result in the HI/LO registers.
// The result is committed to HI/LO only when control issues OPEN_HILO after the iterations finish.
module multu_hilo #(
   parameter int           WIDTH     = 32,
   parameter logic [5:0]   MULTU     = 6'b011001,
   parameter logic [5:0]   OPEN_HILO = 6'b111111
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       Signal,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   output logic [WIDTH-1:0] HiOut,
   output logic [WIDTH-1:0] LoOut,
   output logic             busy,
   output logic             done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]         r_state;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [2*WIDTH-1:0] r_prod;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   logic               w_isMultu;
   logic               w_isOpen;

   assign w_isMultu = (Signal == MULTU);
   assign w_isOpen  = (Signal == OPEN_HILO);

   // Operands are captured only on the IDLE->RUN edge; any non-MULTU opcode during RUN aborts.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_prod   <= '0;
         r_cnt    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_isMultu) begin
                  r_mcand  <= {{WIDTH{1'b0}}, dataA};
                  r_mplier <= dataB;
                  r_prod   <= '0;
                  r_cnt    <= '0;
                  r_state  <= RUN;
               end
            end
            RUN: begin
               if (w_isMultu) begin
                  if (r_mplier[0]) begin
                     r_prod <= r_prod + r_mcand;
                  end
                  r_mcand  <= r_mcand << 1;
                  r_mplier <= r_mplier >> 1;
                  r_cnt    <= r_cnt + 1'b1;
                  if (r_cnt == CNT_LAST) begin
                     r_state <= DONE;
                  end
               end else begin
                  r_state <= IDLE;
               end
            end
            DONE: begin
               if (w_isOpen) begin
                  r_hi    <= r_prod[2*WIDTH-1:WIDTH];
                  r_lo    <= r_prod[WIDTH-1:0];
                  r_state <= IDLE;
               end else if (!w_isMultu) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign HiOut = r_hi;
   assign LoOut = r_lo;
   assign busy  = (r_state == RUN);
   assign done  = (r_state == DONE);

endmodule

// File: tb/tb_multu_hilo.sv
// Directed testbench for multu_hilo: each task drives one scenario and checks its own results.
module tb_multu_hilo;

   localparam logic [5:0] MULTU     = 6'b011001;
   localparam logic [5:0] OPEN_HILO = 6'b111111;
   localparam logic [5:0] ADD       = 6'b100000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [5:0]  Signal = '0;
   logic [31:0] dataA = '0;
   logic [31:0] dataB = '0;
   logic [31:0] HiOut;
   logic [31:0] LoOut;
   logic        busy;
   logic        done;

   int testsRun = 0;
   int testsFailed = 0;

   multu_hilo dut (
      .clk   (clk),
      .rst   (rst),
      .Signal(Signal),
      .dataA (dataA),
      .dataB (dataB),
      .HiOut (HiOut),
      .LoOut (LoOut),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   // Advance one rising edge, then settle so outputs are sampled away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_full(input logic [31:0] a, input logic [31:0] b);
      Signal = MULTU;
      dataA  = a;
      dataB  = b;
      repeat (33) tick();
      Signal = OPEN_HILO;
      tick();
      Signal = 6'd0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      Signal = 6'd0;
      tick();
      testsRun++;
      if ({HiOut, LoOut, busy, done} !== 66'd0) begin
         testsFailed++;
         $display("[TB] FAIL reset: got hi=%h lo=%h busy=%b done=%b, expected all zero", HiOut, LoOut, busy, done);
      end
   endtask

   task automatic test_small();
      int busyCount = 0;
      int overlapCount = 0;
      int earlyDone = 0;
      Signal = MULTU;
      dataA  = 32'd7;
      dataB  = 32'd9;
      for (int i = 1; i <= 33; i++) begin
         tick();
         if (busy) busyCount++;
         if (busy && done) overlapCount++;
         if (i < 33 && done) earlyDone++;
      end
      testsRun++;
      if (busyCount !== 32) begin
         testsFailed++;
         $display("[TB] FAIL small_busy_cycles: got %0d expected 32", busyCount);
      end
      testsRun++;
      if (overlapCount !== 0 || earlyDone !== 0) begin
         testsFailed++;
         $display("[TB] FAIL small_flags: got overlap=%0d earlyDone=%0d expected 0/0", overlapCount, earlyDone);
      end
      testsRun++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL small_done_edge33: got done=%b busy=%b expected 1/0", done, busy);
      end
      testsRun++;
      if (HiOut !== 32'd0 || LoOut !== 32'd0) begin
         testsFailed++;
         $display("[TB] FAIL small_no_early_commit: got %h_%h expected 0_0", HiOut, LoOut);
      end
      Signal = OPEN_HILO;
      tick();
      Signal = 6'd0;
      testsRun++;
      if (HiOut !== 32'd0 || LoOut !== 32'd63 || done !== 1'b0 || busy !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL small_commit: got hi=%h lo=%h done=%b busy=%b expected 0/3f/0/0", HiOut, LoOut, done, busy);
      end
   endtask

   task automatic test_max();
      run_full(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      testsRun++;
      if (HiOut !== 32'hFFFF_FFFE || LoOut !== 32'h0000_0001) begin
         testsFailed++;
         $display("[TB] FAIL max_product: got %h_%h expected fffffffe_00000001", HiOut, LoOut);
      end
   endtask

   task automatic test_abort();
      run_full(32'h8000_0000, 32'd2);
      testsRun++;
      if (HiOut !== 32'd1 || LoOut !== 32'd0) begin
         testsFailed++;
         $display("[TB] FAIL shift_product: got %h_%h expected 00000001_00000000", HiOut, LoOut);
      end
      Signal = MULTU;
      dataA  = 32'd5;
      dataB  = 32'd5;
      repeat (9) tick();
      testsRun++;
      if (busy !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL abort_pre_busy: got %b expected 1", busy);
      end
      Signal = ADD;
      tick();
      testsRun++;
      if (busy !== 1'b0 || done !== 1'b0 || HiOut !== 32'd1 || LoOut !== 32'd0) begin
         testsFailed++;
         $display("[TB] FAIL abort_edge10: got busy=%b done=%b hi=%h lo=%h expected 0/0/1/0", busy, done, HiOut, LoOut);
      end
      Signal = OPEN_HILO;
      tick();
      Signal = 6'd0;
      testsRun++;
      if (HiOut !== 32'd1 || LoOut !== 32'd0) begin
         testsFailed++;
         $display("[TB] FAIL abort_no_commit: got %h_%h expected 00000001_00000000", HiOut, LoOut);
      end
   endtask

   task automatic test_done_hold();
      Signal = MULTU;
      dataA  = 32'd100;
      dataB  = 32'd100;
      repeat (36) tick();
      testsRun++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL done_hold: got done=%b busy=%b expected 1/0", done, busy);
      end
      Signal = ADD;
      tick();
      testsRun++;
      if (done !== 1'b0 || HiOut !== 32'd1 || LoOut !== 32'd0) begin
         testsFailed++;
         $display("[TB] FAIL done_other_opcode: got done=%b hi=%h lo=%h expected 0/1/0", done, HiOut, LoOut);
      end
      Signal = 6'd0;
   endtask

   task automatic test_back_to_back();
      run_full(32'd6, 32'd7);
      testsRun++;
      if (LoOut !== 32'd42 || HiOut !== 32'd0) begin
         testsFailed++;
         $display("[TB] FAIL b2b_first: got %h_%h expected 0_2a", HiOut, LoOut);
      end
      Signal = MULTU;
      dataA  = 32'd2;
      dataB  = 32'd3;
      tick();
      testsRun++;
      if (busy !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL b2b_restart: got busy=%b expected 1", busy);
      end
      repeat (32) tick();
      Signal = OPEN_HILO;
      tick();
      Signal = 6'd0;
      testsRun++;
      if (LoOut !== 32'd6 || HiOut !== 32'd0) begin
         testsFailed++;
         $display("[TB] FAIL b2b_second: got %h_%h expected 0_6", HiOut, LoOut);
      end
   endtask

   task automatic test_reset_midrun();
      Signal = MULTU;
      dataA  = 32'd1000;
      dataB  = 32'd1000;
      repeat (17) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      Signal = 6'd0;
      testsRun++;
      if ({HiOut, LoOut, busy, done} !== 66'd0) begin
         testsFailed++;
         $display("[TB] FAIL reset_midrun: got hi=%h lo=%h busy=%b done=%b expected all zero", HiOut, LoOut, busy, done);
      end
      run_full(32'd3, 32'd5);
      testsRun++;
      if (HiOut !== 32'd0 || LoOut !== 32'd15) begin
         testsFailed++;
         $display("[TB] FAIL after_reset_product: got %h_%h expected 0_f", HiOut, LoOut);
      end
   endtask

   task automatic test_idle_and_operands();
      run_full(32'd7, 32'd9);
      Signal = OPEN_HILO;
      repeat (2) tick();
      Signal = 6'd0;
      testsRun++;
      if (HiOut !== 32'd0 || LoOut !== 32'd63 || busy !== 1'b0 || done !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL idle_open_hilo: got hi=%h lo=%h busy=%b done=%b expected 0/3f/0/0", HiOut, LoOut, busy, done);
      end
      Signal = MULTU;
      dataA  = 32'd11;
      dataB  = 32'd13;
      tick();
      dataA  = 32'hFFFF_FFFF;
      dataB  = 32'hFFFF_FFFF;
      repeat (32) tick();
      Signal = OPEN_HILO;
      tick();
      Signal = 6'd0;
      testsRun++;
      if (HiOut !== 32'd0 || LoOut !== 32'd143) begin
         testsFailed++;
         $display("[TB] FAIL operand_latch: got %h_%h expected 0_8f", HiOut, LoOut);
      end
   endtask

   initial begin
      test_reset();
      test_small();
      test_max();
      test_abort();
      test_done_hold();
      test_back_to_back();
      test_reset_midrun();
      test_idle_and_operands();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
